// File: rtl/pc_addr_stack.sv
// Program counter with a circular return-address stack and a per-cycle address nibble output.
// Define PC_STACK_ERR_EN to build the sticky stack_ovf/stack_unf flags; otherwise both are tied low.
module pc_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 cycle,
    input  logic                       pc_inc,
    input  logic                       pc_load,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          pc_new,
    output logic [ADDR_W-1:0]          pc_addr,
    output logic [3:0]                 pc_nibble,
    output logic [$clog2(DEPTH+1)-1:0] sp_depth,
    output logic                       stack_ovf,
    output logic                       stack_unf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NIBS  = ADDR_W / 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_LOAD,
        OP_PUSH,
        OP_POP
    } op_e;

    op_e               op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] stk_q [DEPTH];
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [WP_W-1:0]   wp_inc, wp_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stk_we;
    logic              full, empty;

    // Only the highest-priority strobe acts on a given edge.
    always_comb begin
        op = OP_NONE;
        if (pop) begin
            op = OP_POP;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pc_load) begin
            op = OP_LOAD;
        end else if (pc_inc) begin
            op = OP_INC;
        end
    end

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wp_inc = (wp_q == WP_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? WP_W'(DEPTH - 1) : wp_q - 1'b1;

    // The pointer always moves circularly; only the count saturates at empty/full.
    always_comb begin
        pc_d   = pc_q;
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        stk_we = 1'b0;
        case (op)
            OP_POP: begin
                pc_d = stk_q[wp_dec];
                wp_d = wp_dec;
                if (!empty) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OP_PUSH: begin
                stk_we = 1'b1;
                wp_d   = wp_inc;
                pc_d   = pc_new;
                if (!full) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OP_LOAD: pc_d = pc_new;
            OP_INC:  pc_d = pc_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            if (stk_we) begin
                stk_q[wp_q] <= pc_q;
            end
        end
    end

`ifdef PC_STACK_ERR_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (op == OP_PUSH && full) begin
                ovf_q <= 1'b1;
            end
            if (op == OP_POP && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    // Phases beyond the last nibble of the address drive zero onto the bus.
    always_comb begin
        pc_nibble = 4'h0;
        for (int k = 0; k < NIBS; k++) begin
            if (cycle == 3'(k)) begin
                pc_nibble = pc_q[4*k +: 4];
            end
        end
    end

    assign pc_addr  = pc_q;
    assign sp_depth = cnt_q;

endmodule
